// File: rtl/layer_mac_seq.sv
// layer_mac_seq: time-multiplexed MAC sequencer for a single fixed-point neuron.
// It produces the same result as the fully parallel neuron:
//   out = sum_k x[k]*w[k] (each product sliced to [FRAC+OUT_W-1:FRAC]) + bias - off,
// with every sum taken mod 2^OUT_W. The terms go one per cycle through a single
// multiplier. The weights and the bias are held in a small config register file.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for an input vector; config writes allowed
// S_MAC  | one multiply-accumulate per cycle, term idx
// S_FIN  | fold in the bias and subtract the offset into out_data
// S_DONE | result presented with out_valid, held until out_ready
module layer_mac_seq #(
  parameter int N_IN  = 6,
  parameter int IN_W  = 9,
  parameter int W_W   = 10,
  parameter int OUT_W = 8,
  parameter int FRAC  = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [W_W-1:0]       cfg_wdata,
  output logic                 cfg_drop,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*IN_W-1:0] in_vec,
  input  logic [IN_W-1:0]      in_off,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 busy
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PW    = IN_W + W_W - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [W_W-1:0]   w_q [N_IN];
  logic [OUT_W-1:0] bias_q;
  logic [IN_W-1:0]  x_q [N_IN];
  logic [OUT_W-1:0] off_q;
  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] out_q;
  logic [IDX_W-1:0] idx_q;
  logic             cfg_drop_q;

  logic             accept;
  logic             cfg_ok;
  logic             last_term;
  logic [IN_W-1:0]  x_sel;
  logic [W_W-1:0]   w_sel;
  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] w_ext;
  logic signed [PW-1:0] prod;
  logic [OUT_W-1:0] slice;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign out_data  = out_q;
  assign cfg_drop  = cfg_drop_q;

  assign accept    = in_valid & in_ready;
  // A write in the same IDLE cycle as an accept lands on that edge, so the
  // accepted vector already sees it: weights are first read in S_MAC and the bias in S_FIN.
  assign cfg_ok    = cfg_we & (state == S_IDLE);
  assign last_term = (idx_q == IDX_W'(N_IN - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept)    state_nxt = S_MAC;
      S_MAC:  if (last_term) state_nxt = S_FIN;
      S_FIN:                 state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // Config register file: weights at 0..N_IN-1, bias at N_IN, other addresses ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_IN; k++) begin
        w_q[k] <= '0;
      end
      bias_q <= '0;
    end else if (cfg_ok) begin
      for (int k = 0; k < N_IN; k++) begin
        if (cfg_addr == 4'(k)) begin
          w_q[k] <= cfg_wdata;
        end
      end
      if (cfg_addr == 4'(N_IN)) begin
        bias_q <= cfg_wdata[OUT_W-1:0];
      end
    end
  end

  // A write attempted while busy is discarded and flagged for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_drop_q <= 1'b0;
    end else begin
      cfg_drop_q <= cfg_we & (state != S_IDLE);
    end
  end

  // Capture the input vector on the accept edge so the source is free afterwards.
  // Only the low OUT_W bits of the offset affect the mod-2^OUT_W result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_IN; k++) begin
        x_q[k] <= '0;
      end
      off_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < N_IN; k++) begin
        x_q[k] <= in_vec[k*IN_W +: IN_W];
      end
      off_q <= OUT_W'(in_off);
    end
  end

  // Term select for the shared multiplier.
  always_comb begin
    x_sel = '0;
    w_sel = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (idx_q == IDX_W'(k)) begin
        x_sel = x_q[k];
        w_sel = w_q[k];
      end
    end
  end

  // Signed full-width product. The arithmetic shift floors the result, and the
  // truncating cast keeps the OUT_W-bit slice. Bits above the slice are dropped.
  always_comb begin
    x_ext = PW'($signed(x_sel));
    w_ext = PW'($signed(w_sel));
    prod  = x_ext * w_ext;
    slice = OUT_W'(prod >>> FRAC);
  end

  // Accumulator, term index and the final bias/offset step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      idx_q <= '0;
      out_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        S_MAC: begin
          acc_q <= acc_q + slice;
          idx_q <= idx_q + 1'b1;
        end
        S_FIN: begin
          out_q <= acc_q + bias_q - off_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mac_seq.sv
// Directed bench for layer_mac_seq. It uses the reference weights
// 015,3B5,00B,00D,017,018 and bias 44. The expected results are worked out by hand.
module tb_layer_mac_seq;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [9:0]  cfg_wdata;
  logic        cfg_drop;
  logic        in_valid;
  logic        in_ready;
  logic [53:0] in_vec;
  logic [8:0]  in_off;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // Test vectors: x0 = 0FF alone, x1 = 0FF alone, all zero.
  localparam logic [53:0] VEC_X0   = 54'h0FF;
  localparam logic [53:0] VEC_X1   = 54'h0FF << 9;
  localparam logic [53:0] VEC_ZERO = 54'h0;

  layer_mac_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_drop  (cfg_drop),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_off    (in_off),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: one config write cycle.
  task automatic cfg_write(input logic [3:0] a, input logic [9:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Stimulus only: present a vector until accepted (bounded), optionally with a
  // config write on the accept cycle. wait_cyc = cycles spent before the accept edge.
  task automatic accept_vec(input logic [53:0] v, input logic [8:0] off,
                            input logic ce, input logic [3:0] a, input logic [9:0] d,
                            output int wait_cyc);
    wait_cyc = 0;
    in_valid = 1'b1; in_vec = v; in_off = off;
    while (!in_ready && wait_cyc < 40) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    cfg_we = ce; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    in_vec = 54'({$urandom(), $urandom()});
    in_off = 9'($urandom());
  endtask

  // Stimulus only: count edges after the accept edge until out_valid (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    vectors++; if (cfg_drop !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_drop got=%b exp=0", cfg_drop); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_program_zero;
    int wc, lat;
    cfg_write(4'd0, 10'h015);
    cfg_write(4'd1, 10'h3B5);
    cfg_write(4'd2, 10'h00B);
    cfg_write(4'd3, 10'h00D);
    cfg_write(4'd4, 10'h017);
    cfg_write(4'd5, 10'h018);
    cfg_write(4'd6, 10'h044);
    vectors++; if (cfg_drop !== 1'b0) begin miscompares++; $display("FAIL idle_write_no_drop got=%b exp=0", cfg_drop); end
    accept_vec(VEC_ZERO, 9'h000, 1'b0, 4'd0, 10'h0, wc);
    vectors++; if (busy !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL zero_busy got busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready); end
    wait_out(lat);
    vectors++; if (lat !== 7) begin miscompares++; $display("FAIL zero_latency got=%0d exp=7", lat); end
    vectors++; if (out_data !== 8'h44) begin miscompares++; $display("FAIL zero_data got=%h exp=44", out_data); end
    release_out();
  endtask

  task automatic test_single_terms;
    int wc, lat;
    accept_vec(VEC_X0, 9'h000, 1'b0, 4'd0, 10'h0, wc);
    wait_out(lat);
    vectors++; if (lat !== 7) begin miscompares++; $display("FAIL x0_latency got=%0d exp=7", lat); end
    vectors++; if (out_data !== 8'h4E) begin miscompares++; $display("FAIL x0_data got=%h exp=4E", out_data); end
    release_out();
    accept_vec(VEC_X1, 9'h000, 1'b0, 4'd0, 10'h0, wc);
    wait_out(lat);
    vectors++; if (out_data !== 8'h1E) begin miscompares++; $display("FAIL x1_wrap_data got=%h exp=1E", out_data); end
    release_out();
  endtask

  task automatic test_offset_hold;
    int wc, lat;
    accept_vec(VEC_ZERO, 9'h1FF, 1'b0, 4'd0, 10'h0, wc);
    wait_out(lat);
    vectors++; if (out_data !== 8'h45) begin miscompares++; $display("FAIL off_data got=%h exp=45", out_data); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b1 || out_data !== 8'h45 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_%0d got valid=%b data=%h in_ready=%b exp valid=1 data=45 in_ready=0", i, out_valid, out_data, in_ready);
      end
    end
    release_out();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL hold_release got valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_cfg_drop;
    int wc, lat;
    accept_vec(VEC_X0, 9'h000, 1'b0, 4'd0, 10'h0, wc);
    cfg_write(4'd0, 10'h1FF);
    vectors++; if (cfg_drop !== 1'b1) begin miscompares++; $display("FAIL drop_pulse got=%b exp=1", cfg_drop); end
    @(posedge clk); #1;
    vectors++; if (cfg_drop !== 1'b0) begin miscompares++; $display("FAIL drop_pulse_end got=%b exp=0", cfg_drop); end
    cfg_write(4'd6, 10'h000);
    wait_out(lat);
    vectors++; if (out_data !== 8'h4E) begin miscompares++; $display("FAIL drop_result got=%h exp=4E", out_data); end
    release_out();
    accept_vec(VEC_X0, 9'h000, 1'b0, 4'd0, 10'h0, wc);
    wait_out(lat);
    vectors++; if (out_data !== 8'h4E) begin miscompares++; $display("FAIL drop_repeat got=%h exp=4E", out_data); end
    release_out();
  endtask

  task automatic test_cfg_on_accept;
    int wc, lat;
    accept_vec(VEC_X0, 9'h000, 1'b1, 4'd6, 10'h010, wc);
    wait_out(lat);
    vectors++; if (out_data !== 8'h1A) begin miscompares++; $display("FAIL accept_write_bias got=%h exp=1A", out_data); end
    release_out();
    cfg_write(4'd6, 10'h044);
    cfg_write(4'd9, 10'h3FF);
    vectors++; if (cfg_drop !== 1'b0) begin miscompares++; $display("FAIL bad_addr_no_drop got=%b exp=0", cfg_drop); end
    cfg_write(4'd15, 10'h3FF);
    accept_vec(VEC_X0, 9'h000, 1'b0, 4'd0, 10'h0, wc);
    wait_out(lat);
    vectors++; if (out_data !== 8'h4E) begin miscompares++; $display("FAIL bad_addr_ignored got=%h exp=4E", out_data); end
    release_out();
  endtask

  task automatic test_back_to_back;
    int wc, lat;
    out_ready = 1'b1;
    accept_vec(VEC_X0, 9'h000, 1'b0, 4'd0, 10'h0, wc);
    wait_out(lat);
    vectors++; if (lat !== 7 || out_data !== 8'h4E) begin miscompares++; $display("FAIL b2b_first got lat=%0d data=%h exp 7/4E", lat, out_data); end
    accept_vec(VEC_X1, 9'h000, 1'b0, 4'd0, 10'h0, wc);
    vectors++; if (wc !== 1) begin miscompares++; $display("FAIL b2b_gap got=%0d exp=1", wc); end
    wait_out(lat);
    vectors++; if (lat !== 7 || out_data !== 8'h1E) begin miscompares++; $display("FAIL b2b_second got lat=%0d data=%h exp 7/1E", lat, out_data); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mac;
    int wc, lat;
    accept_vec(VEC_X0, 9'h000, 1'b0, 4'd0, 10'h0, wc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset got valid=%b busy=%b exp 0/0", out_valid, busy); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    accept_vec(VEC_X0, 9'h000, 1'b0, 4'd0, 10'h0, wc);
    wait_out(lat);
    vectors++; if (lat !== 7 || out_data !== 8'h00) begin miscompares++; $display("FAIL midreset_cleared got lat=%0d data=%h exp 7/00", lat, out_data); end
    release_out();
  endtask

  initial begin
    cfg_we = 1'b0; cfg_addr = 4'd0; cfg_wdata = 10'd0;
    in_valid = 1'b0; in_vec = '0; in_off = '0; out_ready = 1'b0;
    test_reset();
    test_program_zero();
    test_single_terms();
    test_offset_hold();
    test_cfg_drop();
    test_cfg_on_accept();
    test_back_to_back();
    test_reset_mid_mac();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
